// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl
//   Synchronizes and debounces N raw push-buttons, turns each debounced press
//   into a queued one-shot event, and hands pending events one at a time,
//   round-robin, to a single consumer over a valid/ack handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, clears all state
//   btn_in[N]    raw asynchronous button levels (1 = pressed)
//   evt_valid    an event is being offered
//   evt_id[IW]   button index of the offered event
//   evt_ack      consumer accepts the offered event (only seen while offering)
//   pending[N]   per-button queued-event flags
//   overrun[N]   sticky: press arrived while that button's event was pending
//   clr_overrun  clears all overrun bits on the next edge
module btn_event_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned IW       = 2,
  parameter int unsigned DB_TICKS = 500000,
  parameter int unsigned CW       = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  btn_in,
  output logic          evt_valid,
  output logic [IW-1:0] evt_id,
  input  logic          evt_ack,
  output logic [N-1:0]  pending,
  output logic [N-1:0]  overrun,
  input  logic          clr_overrun
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [N-1:0]  s1_q, s1_d;
  logic [N-1:0]  s2_q, s2_d;
  logic [N-1:0]  stable_q, stable_d;
  logic [N-1:0]  stable_dly_q, stable_dly_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  overrun_q, overrun_d;
  logic [0:0]    state_q, state_d;
  logic [IW-1:0] evt_id_q, evt_id_d;
  logic [IW-1:0] last_grant_q, last_grant_d;

  logic [N-1:0]  press;
  logic [N-1:0]  ack_vec;
  logic [N-1:0]  new_ovr;
  logic          found;
  int unsigned   idx;

  always_comb begin
    s1_d         = btn_in;
    s2_d         = s1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DB_TICKS - 1)) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    press   = stable_q & ~stable_dly_q;
    ack_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (state_q == OFFER && evt_ack && evt_id_q == IW'(i)) ack_vec[i] = 1'b1;
    end

    // An ack and a press on the same button in one cycle leave it pending
    // and never count as an overrun.
    pending_d = (pending_q & ~ack_vec) | press;
    new_ovr   = pending_q & press & ~ack_vec;
    overrun_d = clr_overrun ? new_ovr : (overrun_q | new_ovr);

    state_d      = state_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    idx          = 0;
    if (state_q == OFFER) begin
      if (evt_ack) begin
        state_d      = IDLE;
        last_grant_d = evt_id_q;
      end
    end else begin
      // Round-robin: scan upward from the button after the last grant.
      for (int unsigned k = 1; k <= N; k++) begin
        idx = (int'(last_grant_q) + k) % N;
        if (!found && pending_q[idx]) begin
          found    = 1'b1;
          evt_id_d = IW'(idx);
        end
      end
      if (found) state_d = OFFER;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      state_q      <= IDLE;
      evt_id_q     <= '0;
      last_grant_q <= IW'(N - 1);
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      state_q      <= state_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign evt_valid = (state_q == OFFER);
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl (N=4, DB_TICKS=4): directed scenarios followed by
// random button/ack activity, compared every cycle against a reference model.
module tb_btn_event_ctrl;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  btn_in;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          evt_ack;
  logic [N-1:0]  pending;
  logic [N-1:0]  overrun;
  logic          clr_overrun;

  int passed = 0;
  int total  = 0;

  btn_event_ctrl #(.N(N), .IW(IW), .DB_TICKS(DB), .CW(4)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_ack(evt_ack), .pending(pending), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Reference model. Debounced level follows the rule "flip when the last DB
  // synchronized samples all disagree with the current level"; samples reach
  // the debouncer two edges after btn_in is sampled.
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_stable, m_stable_prev, m_pend, m_ovr;
  bit           m_offer;
  int           m_id, m_last;

  task automatic model_reset();
    m_hist.delete();
    m_stable = '0; m_stable_prev = '0; m_pend = '0; m_ovr = '0;
    m_offer = 0; m_id = 0; m_last = N - 1;
  endtask

  task automatic model_edge();
    logic [N-1:0] pr, ack, ov;
    bit all_diff;
    if (reset) begin
      model_reset();
      return;
    end
    pr  = m_stable & ~m_stable_prev;
    ack = '0;
    if (m_offer && evt_ack) ack[m_id] = 1'b1;
    ov  = m_pend & pr & ~ack;
    m_ovr = clr_overrun ? ov : (m_ovr | ov);
    if (m_offer) begin
      if (evt_ack) begin m_offer = 0; m_last = m_id; end
    end else if (m_pend != '0) begin
      for (int k = 1; k <= N; k++)
        if (m_pend[(m_last + k) % N]) begin m_id = (m_last + k) % N; break; end
      m_offer = 1;
    end
    m_pend = (m_pend & ~ack) | pr;
    m_stable_prev = m_stable;
    m_hist.push_back(btn_in);
    if (m_hist.size() > DB + 2) void'(m_hist.pop_front());
    if (m_hist.size() == DB + 2)
      for (int i = 0; i < N; i++) begin
        all_diff = 1;
        for (int k = 0; k < DB; k++) if (m_hist[k][i] == m_stable[i]) all_diff = 0;
        if (all_diff) m_stable[i] = ~m_stable[i];
      end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("evt_valid", {31'd0, evt_valid}, {31'd0, m_offer});
    chk("evt_id", {30'd0, evt_id}, m_id);
    chk("pending", {28'd0, pending}, {28'd0, m_pend});
    chk("overrun", {28'd0, overrun}, {28'd0, m_ovr});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Bounded wait for evt_valid; returns the edge count (limit+1 on timeout).
  task automatic wait_valid(input int limit, output int n);
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (evt_valid) begin n = i; break; end
    end
  endtask

  initial begin
    int n;
    model_reset();
    reset = 1'b1; btn_in = '0; evt_ack = 1'b0; clr_overrun = 1'b0;
    steps(2);
    reset = 1'b0;
    steps(1);
    chk("reset_last_grant_pending", {28'd0, pending}, 32'd0);

    // Single press, ack tied high: event at edge DB+4.
    btn_in = 4'b0001; evt_ack = 1'b1;
    wait_valid(20, n);
    chk("press_latency", n, 8);
    chk("first_id", {30'd0, evt_id}, 32'd0);
    steps(12);
    btn_in = '0; steps(10);

    // Short glitch must be swallowed.
    btn_in = 4'b0100; steps(3);
    btn_in = '0; steps(10);
    chk("glitch_no_pending", {28'd0, pending}, 32'd0);

    // Simultaneous presses: round-robin ordering.
    btn_in = 4'b1010; steps(14);
    btn_in = '0;      steps(10);
    btn_in = 4'b0011; steps(14);
    btn_in = '0;      steps(10);

    // Overrun with consumer stalled, then clear and ack.
    evt_ack = 1'b0;
    btn_in = 4'b0100; steps(10);
    btn_in = '0;      steps(8);
    btn_in = 4'b0100; steps(10);
    chk("overrun2_set", {31'd0, overrun[2]}, 32'd1);
    chk("offer_held_id2", {30'd0, evt_id}, 32'd2);
    clr_overrun = 1'b1; steps(1);
    clr_overrun = 1'b0; steps(1);
    chk("overrun_cleared", {28'd0, overrun}, 32'd0);
    evt_ack = 1'b1; steps(1);
    evt_ack = 1'b0; steps(2);
    chk("pending2_cleared", {31'd0, pending[2]}, 32'd0);
    btn_in = '0; steps(10);

    // Ack on the same edge a new press on button 1 registers.
    btn_in = 4'b0010; steps(10);
    btn_in = '0;      steps(8);
    btn_in = 4'b0010; steps(6);
    evt_ack = 1'b1;   steps(1);
    evt_ack = 1'b0;
    chk("ack_press_pending1", {31'd0, pending[1]}, 32'd1);
    chk("ack_press_no_ovr", {31'd0, overrun[1]}, 32'd0);
    steps(2);
    chk("second_offer_id1", {29'd0, evt_valid, evt_id}, 32'h5);

    // Reset while offering, button still held.
    reset = 1'b1; steps(1);
    reset = 1'b0;
    chk("reset_drops_offer", {31'd0, evt_valid}, 32'd0);
    wait_valid(20, n);
    chk("held_after_reset_latency", n, 8);
    evt_ack = 1'b1; steps(2);
    btn_in = '0; evt_ack = 1'b0; steps(10);

    // Random activity.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5) == 0) btn_in[$urandom_range(N - 1)] ^= 1'b1;
      evt_ack     = ($urandom_range(2) == 0);
      clr_overrun = ($urandom_range(40) == 0);
      reset       = ($urandom_range(300) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
